// File: rtl/imem_loader_pkg.sv
// Shared definitions for the RISC-V instruction-memory loader.
package imem_loader_pkg;

   // Loader sequencing states
   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_RECV  = 3'd1,
      ST_WRITE = 3'd2,
      ST_DONE  = 3'd3,
      ST_ERR   = 3'd4
   } loader_state_e;

   // Default byte address of the first instruction word in memory
   localparam logic [31:0] IMEM_BASE_ADDR = 32'h0100_0000;

   // Bit offset of byte lane 'idx' inside a little-endian 32-bit word
   function automatic logic [4:0] lane_offset(input logic [1:0] idx);
      return {idx, 3'b000};
   endfunction

endpackage

// File: rtl/imem_loader_byte_assembler.sv
// Collects program bytes, little-endian, into one 32-bit instruction word.
module byte_assembler
   import imem_loader_pkg::*;
(
   input  logic        clk,
   input  logic        rst,
   input  logic        clear,
   input  logic        accept,
   input  logic [7:0]  byte_data,
   output logic [31:0] word,
   output logic        full
);

   logic [1:0]  index_r;
   logic [31:0] assembly_r;

   // Byte-lane counter and assembly register; clear zeroes unfilled lanes for the next word
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         index_r    <= 2'd0;
         assembly_r <= 32'd0;
      end else if (clear) begin
         index_r    <= 2'd0;
         assembly_r <= 32'd0;
      end else if (accept) begin
         assembly_r[lane_offset(index_r) +: 8] <= byte_data;
         index_r                               <= index_r + 2'd1;
      end
   end

   assign word = assembly_r;
   // The next accepted byte completes the word
   assign full = (index_r == 2'd3);

endmodule

// File: rtl/imem_loader.sv
// Streams a byte image into instruction memory word by word while holding the CPU.
module imem_loader
   import imem_loader_pkg::*;
#(
   parameter int                AWIDTH    = 32,
   parameter int                DWIDTH    = 32,
   parameter logic [AWIDTH-1:0] BASE_ADDR = AWIDTH'(IMEM_BASE_ADDR),
   parameter int                MAX_WORDS = 1024
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start_i,
   input  logic              byte_valid_i,
   input  logic [7:0]        byte_data_i,
   input  logic              byte_last_i,
   output logic              byte_ready_o,
   output logic [AWIDTH-1:0] mem_addr_o,
   output logic [DWIDTH-1:0] mem_data_o,
   output logic              mem_write_en_o,
   output logic              mem_read_en_o,
   output logic              busy_o,
   output logic              done_o,
   output logic              error_o,
   output logic              cpu_hold_o,
   output logic [15:0]       word_count_o
);

   localparam logic [15:0] MAX_COUNT = 16'(MAX_WORDS);

   loader_state_e state_r;
   loader_state_e next_state_s;
   logic [15:0]   word_count_r;
   logic          last_r;
   logic          ready_s;
   logic          accept_s;
   logic          overflow_s;
   logic          load_start_s;
   logic          clear_s;
   logic          full_s;
   logic [31:0]   word_s;

   // Bytes are only taken while receiving and while there is still room for another word
   assign ready_s      = (state_r == ST_RECV) && (word_count_r < MAX_COUNT);
   assign accept_s     = byte_valid_i && ready_s;
   assign overflow_s   = (state_r == ST_RECV) && byte_valid_i && (word_count_r >= MAX_COUNT);
   assign load_start_s = start_i && ((state_r == ST_IDLE) || (state_r == ST_DONE) || (state_r == ST_ERR));
   // Assembly restarts on a new load and right after every word is written
   assign clear_s      = load_start_s || (state_r == ST_WRITE);

   byte_assembler u_assembler (
      .clk       (clk),
      .rst       (rst),
      .clear     (clear_s),
      .accept    (accept_s),
      .byte_data (byte_data_i),
      .word      (word_s),
      .full      (full_s)
   );

   // State register
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_r <= ST_IDLE;
      end else begin
         state_r <= next_state_s;
      end
   end

   // Next-state decode
   always_comb begin
      next_state_s = state_r;
      case (state_r)
         ST_IDLE: begin
            if (start_i) next_state_s = ST_RECV;
            else         next_state_s = ST_IDLE;
         end
         ST_RECV: begin
            if (overflow_s)                            next_state_s = ST_ERR;
            else if (accept_s && (full_s || byte_last_i)) next_state_s = ST_WRITE;
            else                                       next_state_s = ST_RECV;
         end
         ST_WRITE: begin
            if (last_r) next_state_s = ST_DONE;
            else        next_state_s = ST_RECV;
         end
         ST_DONE, ST_ERR: begin
            if (start_i) next_state_s = ST_RECV;
            else         next_state_s = state_r;
         end
         default: next_state_s = ST_IDLE;
      endcase
   end

   // Word counter advances as each write completes; last_r remembers whether the word ends the image
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         word_count_r <= 16'd0;
         last_r       <= 1'b0;
      end else if (load_start_s) begin
         word_count_r <= 16'd0;
         last_r       <= 1'b0;
      end else begin
         if (state_r == ST_WRITE) word_count_r <= word_count_r + 16'd1;
         if (accept_s)            last_r       <= byte_last_i;
      end
   end

   // Moore output decode; the memory bus is driven to zero outside the write cycle
   always_comb begin
      mem_write_en_o = 1'b0;
      mem_addr_o     = {AWIDTH{1'b0}};
      mem_data_o     = {DWIDTH{1'b0}};
      busy_o         = 1'b0;
      done_o         = 1'b0;
      error_o        = 1'b0;
      cpu_hold_o     = 1'b1;
      case (state_r)
         ST_RECV: begin
            busy_o = 1'b1;
         end
         ST_WRITE: begin
            busy_o         = 1'b1;
            mem_write_en_o = 1'b1;
            mem_addr_o     = BASE_ADDR + AWIDTH'({word_count_r, 2'b00});
            mem_data_o     = DWIDTH'(word_s);
         end
         ST_DONE: begin
            done_o     = 1'b1;
            cpu_hold_o = 1'b0;
         end
         ST_ERR: begin
            error_o = 1'b1;
         end
         default: begin
            cpu_hold_o = 1'b1;
         end
      endcase
   end

   assign byte_ready_o  = ready_s;
   assign mem_read_en_o = 1'b0;
   assign word_count_o  = word_count_r;

endmodule

// File: tb/tb_imem_loader.sv
// Randomized self-checking bench for imem_loader with a word-level reference model.
module tb_imem_loader;

   localparam logic [31:0] BASE = 32'h0100_0000;

   logic       clk   = 1'b0;
   logic       rst   = 1'b1;
   logic       start = 1'b0;
   logic       valid = 1'b0;
   logic       last  = 1'b0;
   logic       sel   = 1'b0;
   logic [7:0] data  = 8'h00;

   int n_checks = 0;
   int n_fail   = 0;

   logic [7:0]  stim_q[$];
   logic [63:0] got_q[$];

   logic a_ready, a_wen, a_ren, a_busy, a_done, a_err, a_hold;
   logic b_ready, b_wen, b_ren, b_busy, b_done, b_err, b_hold;
   logic [31:0] a_addr, a_data, b_addr, b_data;
   logic [15:0] a_cnt, b_cnt;
   logic c_ready, c_wen, c_ren, c_busy, c_done, c_err, c_hold;
   logic [31:0] c_addr, c_data;
   logic [15:0] c_cnt;

   always #5 clk = ~clk;

   imem_loader dut_a (
      .clk(clk), .rst(rst), .start_i(start & ~sel), .byte_valid_i(valid & ~sel),
      .byte_data_i(data), .byte_last_i(last), .byte_ready_o(a_ready),
      .mem_addr_o(a_addr), .mem_data_o(a_data), .mem_write_en_o(a_wen),
      .mem_read_en_o(a_ren), .busy_o(a_busy), .done_o(a_done), .error_o(a_err),
      .cpu_hold_o(a_hold), .word_count_o(a_cnt)
   );

   imem_loader #(.MAX_WORDS(2)) dut_b (
      .clk(clk), .rst(rst), .start_i(start & sel), .byte_valid_i(valid & sel),
      .byte_data_i(data), .byte_last_i(last), .byte_ready_o(b_ready),
      .mem_addr_o(b_addr), .mem_data_o(b_data), .mem_write_en_o(b_wen),
      .mem_read_en_o(b_ren), .busy_o(b_busy), .done_o(b_done), .error_o(b_err),
      .cpu_hold_o(b_hold), .word_count_o(b_cnt)
   );

   assign c_ready = sel ? b_ready : a_ready;
   assign c_wen   = sel ? b_wen   : a_wen;
   assign c_ren   = sel ? b_ren   : a_ren;
   assign c_busy  = sel ? b_busy  : a_busy;
   assign c_done  = sel ? b_done  : a_done;
   assign c_err   = sel ? b_err   : a_err;
   assign c_hold  = sel ? b_hold  : a_hold;
   assign c_addr  = sel ? b_addr  : a_addr;
   assign c_data  = sel ? b_data  : a_data;
   assign c_cnt   = sel ? b_cnt   : a_cnt;

   task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   // Write monitor: collects every memory write, checks bus idle values and ready during writes
   always @(negedge clk) begin
      check_eq("read_en_zero", c_ren, 1'b0);
      if (c_wen) begin
         got_q.push_back({c_addr, c_data});
         check_eq("ready_in_write", c_ready, 1'b0);
      end else begin
         check_eq("addr_idle_zero", c_addr, 32'h0);
         check_eq("data_idle_zero", c_data, 32'h0);
      end
   end

   task automatic pulse_start();
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
   endtask

   task automatic check_reset_values();
      check_eq("rst_ready", c_ready, 1'b0);
      check_eq("rst_wen",   c_wen,   1'b0);
      check_eq("rst_busy",  c_busy,  1'b0);
      check_eq("rst_done",  c_done,  1'b0);
      check_eq("rst_error", c_err,   1'b0);
      check_eq("rst_hold",  c_hold,  1'b1);
      check_eq("rst_count", c_cnt,   16'd0);
   endtask

   // Offer one byte (after 'gap' idle cycles) and wait until it is taken or the loader errors
   task automatic send_byte(input logic [7:0] b, input logic is_last, input int gap,
                            input bit poke, output bit taken);
      int n;
      for (int g = 0; g < gap; g++) begin
         valid = 1'b0;
         last  = 1'($urandom_range(0, 1));
         @(negedge clk);
      end
      valid = 1'b1;
      data  = b;
      last  = is_last;
      start = poke;
      n = 0;
      while (!c_ready && !c_err && n < 40) begin
         @(negedge clk);
         start = 1'b0;
         n++;
      end
      taken = 1'b0;
      if (c_err) begin
         valid = 1'b0; last = 1'b0; start = 1'b0;
      end else if (n >= 40) begin
         check_eq("ready_timeout", 1'b1, 1'b0);
         valid = 1'b0; last = 1'b0; start = 1'b0;
      end else begin
         @(negedge clk);
         valid = 1'b0; last = 1'b0; start = 1'b0;
         taken = 1'b1;
      end
   endtask

   // Load stim_q into the selected loader and compare against the word-level model
   task automatic run_load(input bit use_b, input int min_gap, input int max_gap, input bit pokes);
      int maxw, n, nw, ew, t;
      bit exp_err, taken;
      logic [31:0] exp_word;
      sel  = use_b;
      maxw = use_b ? 2 : 1024;
      n    = stim_q.size();
      nw   = (n + 3) / 4;
      exp_err = (nw > maxw);
      ew   = exp_err ? maxw : nw;
      @(negedge clk);
      got_q.delete();
      pulse_start();
      check_eq("count_after_start", c_cnt, 16'd0);
      check_eq("busy_after_start", c_busy, 1'b1);
      for (int i = 0; i < n; i++) begin
         send_byte(stim_q[i], (i == n - 1), $urandom_range(min_gap, max_gap),
                   pokes && (i > 0) && ($urandom_range(0, 3) == 0), taken);
         if (!taken) break;
         if ((i % 4 == 3) || (i == n - 1)) begin
            check_eq("write_latency", c_wen, 1'b1);
            if (i != n - 1) begin
               @(negedge clk);
               check_eq("ready_after_write", c_ready, ((i + 1) / 4) < maxw);
            end
         end
      end
      t = 0;
      while (!c_done && !c_err && t < 20) begin
         @(negedge clk);
         t++;
      end
      if (t >= 20) check_eq("end_timeout", 1'b1, 1'b0);
      repeat (2) @(negedge clk);
      check_eq("n_writes", got_q.size(), ew);
      for (int w = 0; w < ew && w < got_q.size(); w++) begin
         exp_word = 32'h0;
         for (int k = 0; k < 4; k++)
            if (4 * w + k < n) exp_word = exp_word | (32'(stim_q[4 * w + k]) << (8 * k));
         check_eq("wr_addr", got_q[w][63:32], BASE + 32'(4 * w));
         check_eq("wr_data", got_q[w][31:0], exp_word);
      end
      check_eq("end_done",  c_done,  !exp_err);
      check_eq("end_error", c_err,   exp_err);
      check_eq("end_count", c_cnt,   16'(ew));
      check_eq("end_hold",  c_hold,  exp_err);
      check_eq("end_busy",  c_busy,  1'b0);
      check_eq("end_ready", c_ready, 1'b0);
   endtask

   task automatic random_stim(input int len);
      stim_q.delete();
      for (int i = 0; i < len; i++) stim_q.push_back(8'($urandom_range(0, 255)));
   endtask

   initial begin
      #500_000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog expired");
   end

   initial begin
      bit taken;
      int len;
      bit use_b;
      // Power-on reset
      #2 rst = 1'b0;
      #1 check_reset_values();
      @(negedge clk);
      @(negedge clk);
      check_reset_values();
      rst = 1'b1;

      // Single instruction: addi a0,x0,0 style word 0x00000513
      stim_q = '{8'h13, 8'h05, 8'h00, 8'h00};
      run_load(1'b0, 0, 0, 1'b0);
      check_eq("first_data", (got_q.size() > 0) ? got_q[0][31:0] : 32'hDEAD_BEEF, 32'h0000_0513);

      // Two words with gaps between bytes; restart from DONE resets addressing
      random_stim(8);
      run_load(1'b0, 1, 2, 1'b0);

      // Partial final word is zero-padded
      stim_q = '{8'hAA, 8'hBB, 8'hCC, 8'hDD, 8'hEE};
      run_load(1'b0, 0, 1, 1'b1);

      // Overflow with a two-word limit: error on the ninth byte, no third write
      random_stim(12);
      run_load(1'b1, 0, 1, 1'b0);

      // Reset mid-word aborts without writing
      sel = 1'b0;
      @(negedge clk);
      got_q.delete();
      pulse_start();
      send_byte(8'h11, 1'b0, 0, 1'b0, taken);
      send_byte(8'h22, 1'b0, 0, 1'b0, taken);
      #2 rst = 1'b0;
      #1 check_reset_values();
      @(negedge clk);
      check_reset_values();
      rst = 1'b1;
      @(negedge clk);
      check_eq("rst_no_write", got_q.size(), 0);
      random_stim(4);
      run_load(1'b0, 0, 1, 1'b0);

      // Randomized loads on both limits, with stray start pulses mid-load
      for (int r = 0; r < 25; r++) begin
         use_b = ($urandom_range(0, 3) == 0);
         len   = use_b ? $urandom_range(1, 14) : $urandom_range(1, 40);
         random_stim(len);
         run_load(use_b, 0, 2, 1'b1);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/imem_loader.md
IMEM_LOADER -- requirements
Module: imem_loader

Interface
REQ-001 SHALL have parameter AWIDTH, default 32, address width.
REQ-002 SHALL have parameter DWIDTH, default 32, memory word width.
REQ-003 SHALL have parameter BASE_ADDR, default 32'h0100_0000, byte address of the first written word.
REQ-004 SHALL have parameter MAX_WORDS, default 1024, maximum words per load.
REQ-005 SHALL have one clock; reset is asynchronous and active-low:
  clk             in   1       clock, rising edge
  rst             in   1       asynchronous, active-low reset
  start_i         in   1       begin a new load (single-cycle pulse)
  byte_valid_i    in   1       byte_data_i valid
  byte_data_i     in   8       program byte, little-endian order
  byte_last_i     in   1       qualifies the final byte of the image
  byte_ready_o    out  1       loader accepts a byte this cycle
  mem_addr_o      out  AWIDTH  memory write address
  mem_data_o      out  DWIDTH  memory write data
  mem_write_en_o  out  1       memory write strobe, one cycle per word
  mem_read_en_o   out  1       constant 0
  busy_o          out  1       load in progress
  done_o          out  1       load completed without error
  error_o         out  1       overflow detected
  cpu_hold_o      out  1       keeps fetch/decode held; 0 only in DONE
  word_count_o    out  16      words written in the current load

Function
REQ-006 SHALL implement FSM states IDLE, RECV, WRITE, DONE, ERR.
REQ-007 IDLE: start_i=1 -> RECV; clear word count, byte index and assembly register.
REQ-008 A byte SHALL be accepted iff byte_valid_i && byte_ready_o; byte_ready_o=1 only in RECV.
REQ-009 Accepted byte k (k=0..3) SHALL go to bits [8k+7:8k] of the assembly word; the byte index wraps 3->0.
REQ-010 On acceptance of byte 3, or of any byte with byte_last_i=1: go to WRITE; unfilled upper bytes SHALL be zero.
REQ-011 WRITE SHALL last exactly one cycle: mem_write_en_o=1, mem_addr_o=BASE_ADDR+4*word_count_o, mem_data_o=assembled word.
REQ-012 Word count SHALL increment at WRITE exit; next state is DONE if the write carried byte_last_i, else RECV.
REQ-013 Latency: 4th byte accepted in cycle N -> write strobe in cycle N+1 -> byte_ready_o=1 again in cycle N+2.
REQ-014 A byte offered in RECV with word_count_o==MAX_WORDS SHALL go to ERR with no write; that byte is not accepted.
REQ-015 start_i SHALL be ignored in RECV and WRITE.
REQ-016 DONE and ERR SHALL hold until start_i=1, then restart as in REQ-007.
REQ-017 Outputs: busy_o=1 in RECV/WRITE; done_o=1 in DONE; error_o=1 in ERR; cpu_hold_o=0 only in DONE.
REQ-018 mem_addr_o and mem_data_o SHALL be 0 whenever mem_write_en_o=0.
REQ-019 byte_last_i on an idle handshake (valid=0) SHALL be ignored.

Reset
REQ-020 rst=0 SHALL immediately force IDLE, count=0, byte index=0, assembly=0.
REQ-021 During reset: byte_ready_o=0, mem_write_en_o=0, busy_o=0, done_o=0, error_o=0, cpu_hold_o=1, word_count_o=0.
REQ-022 Reset mid-load SHALL abort it; a partially assembled word SHALL never be written.

Structure
REQ-023 The state enum and the BASE_ADDR default SHALL live in the shared package for the project's RISC-V design; memory width parameters SHALL follow the existing AWIDTH/DWIDTH scheme.
REQ-024 There SHALL be one sub-module, byte_assembler: byte index counter plus assembly register, with clear/accept inputs and word/full outputs.

Verification
REQ-025 Start, then bytes 13,05,00,00 (last on byte 4) -> one write, addr 0x01000000, data 0x00000513; then DONE, word_count=1, cpu_hold_o=0.
REQ-026 8 bytes with valid gaps -> writes to 0x01000000 and 0x01000004; byte_ready_o low during each WRITE cycle.
REQ-027 5 bytes AA,BB,CC,DD,EE (last on EE) -> 0xDDCCBBAA, then 0x000000EE at 0x01000004; then DONE.
REQ-028 MAX_WORDS=2 with 12 bytes -> two writes, then ERR on byte 9, error_o=1, no third write.
REQ-029 rst low after 2 bytes -> no write, all outputs at reset values; then start plus 4 bytes -> write at BASE_ADDR.
REQ-030 start_i pulsed during RECV -> ignored; start_i in DONE -> word_count_o=0, next write at BASE_ADDR.
